mips_cpu_ram_ws: RTL

//  Parametrised successor RAM for the MIPS CPU testbench: Avalon-MM slave with two word-organised windows.
//  The reset-vector window starts at 0xBFC00000; the data window starts at 0x00000000.

---
 rtl/mips_cpu_pkg.sv | 24 ++
 rtl/mips_cpu_ram_ws_if.sv | 23 ++
 rtl/mips_cpu_ram_wait_gen.sv | 54 +++++
 rtl/mips_cpu_ram_ws.sv | 90 +++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared constants and types for the MIPS CPU bench memory models.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] DATA_BASE    = 32'h00000000;

    typedef logic [0:0] ram_state_t;
    localparam ram_state_t IDLE = 1'b0;
    localparam ram_state_t WAIT = 1'b1;

    // x^16+x^14+x^13+x^11 in right-shifting Galois form
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef struct packed {
        logic hit_rst;
        logic hit_dat;
        logic ok;
    } ram_dec_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/mips_cpu_ram_ws_if.sv
// Avalon-MM slave bus between the CPU memory port and the bench RAM.
interface mips_cpu_ram_ws_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest, bus_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest, bus_error
    );

endinterface

// File: rtl/mips_cpu_ram_wait_gen.sv
// Wait-state generator: IDLE/WAIT FSM, down-counter and LFSR for randomised wait lengths.
module mips_cpu_ram_wait_gen
    import mips_cpu_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done,
    input  logic abort,
    output logic busy,
    output logic waitrequest
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    ram_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [15:0]   lfsr;

    // The target only matters in IDLE; the LFSR is frozen between completions.
    always_comb begin
        target = CW'(WAIT_STATES);
        if (RANDOM_WAIT) target = CW'(lfsr % 16'(WAIT_STATES + 1));
    end

    assign busy        = (state == WAIT);
    assign waitrequest = start && ((state == IDLE) ? (target != '0) : (cnt != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
        end else begin
            if (done) lfsr <= lfsr_next(lfsr);
            if (state == IDLE) begin
                if (start && target != '0) begin
                    state <= WAIT;
                    cnt   <= target - 1'b1;
                end
            end else if (abort || cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_ram_ws.sv
// Bench RAM for the MIPS CPU: reset-vector and data windows behind an Avalon-MM slave,
// with fixed or pseudo-random wait states and a sticky bus-error flag.
module mips_cpu_ram_ws
    import mips_cpu_pkg::*;
#(
    parameter int          RESET_WORDS = 64,
    parameter int          DATA_WORDS  = 1024,
    parameter int          WAIT_STATES = 0,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic              clk,
    input logic              reset,
    mips_cpu_ram_ws_if.slave bus
);

    localparam int RA = $clog2(RESET_WORDS);
    localparam int DA = $clog2(DATA_WORDS);

    logic          req, done, abort, busy, wreq, wr_en;
    logic [31:0]   off_rst, off_dat;
    logic [RA-1:0] rst_idx;
    logic [DA-1:0] dat_idx;
    ram_dec_t      dec;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0] rst_mem [RESET_WORDS];
    logic [31:0] dat_mem [DATA_WORDS];

    assign req     = bus.read | bus.write;
    assign off_rst = bus.address - RESET_VECTOR;
    assign off_dat = bus.address - DATA_BASE;
    assign rst_idx = off_rst[RA+1:2];
    assign dat_idx = off_dat[DA+1:2];

    always_comb begin
        dec.hit_rst = (bus.address[31:24] == 8'hBF) && (off_rst < 32'(RESET_WORDS * 4));
        dec.hit_dat = (off_dat < 32'(DATA_WORDS * 4));
        dec.ok      = (bus.address[1:0] == 2'b00) && (dec.hit_rst || dec.hit_dat);
    end

    mips_cpu_ram_wait_gen #(
        .WAIT_STATES (WAIT_STATES),
        .RANDOM_WAIT (RANDOM_WAIT),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait (
        .clk         (clk),
        .reset       (reset),
        .start       (req),
        .done        (done),
        .abort       (abort),
        .busy        (busy),
        .waitrequest (wreq)
    );

    // Gating with reset keeps a zero-wait access from landing while reset is held.
    assign done  = req && !wreq && !reset;
    assign abort = busy && !req;
    assign wr_en = done && bus.write && dec.ok;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    if (dec.hit_rst) rst_mem[rst_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                    else             dat_mem[dat_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    // read&&write is serviced as a write, so readdata is only loaded for pure reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (abort || (done && (!dec.ok || (bus.read && bus.write)))) err_q <= 1'b1;
            if (done && bus.read && !bus.write)
                rdata_q <= !dec.ok     ? '0 :
                           dec.hit_rst ? rst_mem[rst_idx] : dat_mem[dat_idx];
        end
    end

    assign bus.waitrequest = wreq;
    assign bus.readdata    = rdata_q;
    assign bus.bus_error   = err_q;

endmodule
